// File: rtl/jtag_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jtag_pkg
//  Description : Shared types for the JTAG TAP controller: TAP state
//                encoding, opcode values, DR selector and state decodes.
//  Revision    : 1.0 - initial release
// ============================================================================
package jtag_pkg;

  // Standard 1149.1 state encoding
  typedef enum logic [3:0] {
    EXIT2_DR         = 4'h0,
    EXIT1_DR         = 4'h1,
    SHIFT_DR         = 4'h2,
    PAUSE_DR         = 4'h3,
    SELECT_IR_SCAN   = 4'h4,
    UPDATE_DR        = 4'h5,
    CAPTURE_DR       = 4'h6,
    SELECT_DR_SCAN   = 4'h7,
    EXIT2_IR         = 4'h8,
    EXIT1_IR         = 4'h9,
    SHIFT_IR         = 4'hA,
    PAUSE_IR         = 4'hB,
    RUN_TEST_IDLE    = 4'hC,
    UPDATE_IR        = 4'hD,
    CAPTURE_IR       = 4'hE,
    TEST_LOGIC_RESET = 4'hF
  } tap_state_e;

  // Opcodes that are not all-0 (EXTEST) or all-1 (BYPASS); widened to IR_WIDTH at use
  localparam int OPC_IDCODE         = 1;
  localparam int OPC_SAMPLE_PRELOAD = 2;
  // Value loaded into the IR shift stage on CAPTURE_IR (ends in 2'b01)
  localparam int IR_CAPTURE_VAL     = 1;

  typedef enum logic [1:0] {
    DR_BSR    = 2'd0,
    DR_IDCODE = 2'd1,
    DR_BYPASS = 2'd2
  } dr_sel_e;

  // One-hot decodes of the states the datapath acts on
  typedef struct packed {
    logic tlr;
    logic capture_dr;
    logic shift_dr;
    logic update_dr;
    logic capture_ir;
    logic shift_ir;
    logic update_ir;
  } tap_dec_t;

endpackage
`default_nettype wire

// File: rtl/jtag_tap_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : jtag_tap_fsm
//  Description : 16-state TAP state machine advanced by the TCK-edge strobe,
//                with one-hot decodes of the states used by the datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     tck_enable,
  input  logic     tms,
  output tap_dec_t dec
);

  tap_state_e state;
  tap_state_e state_nxt;

  // State register: moves only on a TCK strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= TEST_LOGIC_RESET;
    end else if (tck_enable) begin
      state <= state_nxt;
    end
  end

  // TMS transition graph and state decodes
  always_comb begin
    state_nxt = state;
    dec       = '0;
    unique case (state)
      TEST_LOGIC_RESET: state_nxt = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    state_nxt = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_DR_SCAN:   state_nxt = tms ? SELECT_IR_SCAN   : CAPTURE_DR;
      CAPTURE_DR:       state_nxt = tms ? EXIT1_DR         : SHIFT_DR;
      SHIFT_DR:         state_nxt = tms ? EXIT1_DR         : SHIFT_DR;
      EXIT1_DR:         state_nxt = tms ? UPDATE_DR        : PAUSE_DR;
      PAUSE_DR:         state_nxt = tms ? EXIT2_DR         : PAUSE_DR;
      EXIT2_DR:         state_nxt = tms ? UPDATE_DR        : SHIFT_DR;
      UPDATE_DR:        state_nxt = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_IR_SCAN:   state_nxt = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       state_nxt = tms ? EXIT1_IR         : SHIFT_IR;
      SHIFT_IR:         state_nxt = tms ? EXIT1_IR         : SHIFT_IR;
      EXIT1_IR:         state_nxt = tms ? UPDATE_IR        : PAUSE_IR;
      PAUSE_IR:         state_nxt = tms ? EXIT2_IR         : PAUSE_IR;
      EXIT2_IR:         state_nxt = tms ? UPDATE_IR        : SHIFT_IR;
      UPDATE_IR:        state_nxt = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      default:          state_nxt = TEST_LOGIC_RESET;
    endcase
    dec.tlr        = (state == TEST_LOGIC_RESET);
    dec.capture_dr = (state == CAPTURE_DR);
    dec.shift_dr   = (state == SHIFT_DR);
    dec.update_dr  = (state == UPDATE_DR);
    dec.capture_ir = (state == CAPTURE_IR);
    dec.shift_ir   = (state == SHIFT_IR);
    dec.update_ir  = (state == UPDATE_IR);
  end

endmodule
`default_nettype wire

// File: rtl/jtag_tap_controller.sv
`default_nettype none
// ============================================================================
//  Module      : jtag_tap_controller
//  Description : 1149.1-style TAP controller on the system clock, qualified
//                by a TCK-edge strobe. Holds IR, bypass and IDCODE registers,
//                muxes TDO and decodes boundary-scan cell controls.
//  Revision    : 1.0 - initial release
// ============================================================================
module jtag_tap_controller
  import jtag_pkg::*;
#(
  parameter int          IR_WIDTH   = 4,
  parameter logic [31:0] IDCODE_VAL = 32'h1BA5_E0F3
)(
  input  logic internal_clk,
  input  logic tap_reset_n,
  input  logic tck_enable,
  input  logic tms,
  input  logic tdi,
  output logic tdo,
  output logic tdo_oe,
  output logic bsr_tck_enable,
  output logic bsr_test_logic_reset,
  output logic bsr_capture,
  output logic bsr_shift_data,
  output logic bsr_update,
  output logic bsr_mode,
  output logic bsr_scan_in,
  input  logic bsr_scan_out
);

  localparam logic [IR_WIDTH-1:0] IR_EXTEST  = '0;
  localparam logic [IR_WIDTH-1:0] IR_SAMPLE  = IR_WIDTH'(OPC_SAMPLE_PRELOAD);
  localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(OPC_IDCODE);
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(IR_CAPTURE_VAL);

  tap_dec_t            dec;
  dr_sel_e             dr_sel;
  logic [IR_WIDTH-1:0] ir_shift;
  logic [IR_WIDTH-1:0] ir_active;
  logic                bypass;
  logic [31:0]         id_shift;

  jtag_tap_fsm u_fsm (
    .clk        (internal_clk),
    .rst_n      (tap_reset_n),
    .tck_enable (tck_enable),
    .tms        (tms),
    .dec        (dec)
  );

  // Instruction register: capture/shift stage and the active instruction
  always_ff @(posedge internal_clk or negedge tap_reset_n) begin
    if (!tap_reset_n) begin
      ir_shift  <= '0;
      ir_active <= IR_IDCODE;
    end else if (tck_enable) begin
      if (dec.capture_ir) ir_shift <= IR_CAPTURE;
      if (dec.shift_ir)   ir_shift <= {tdi, ir_shift[IR_WIDTH-1:1]};
      if (dec.update_ir)  ir_active <= ir_shift;
      if (dec.tlr)        ir_active <= IR_IDCODE;
    end
  end

  // Bypass and IDCODE data registers
  always_ff @(posedge internal_clk or negedge tap_reset_n) begin
    if (!tap_reset_n) begin
      bypass   <= 1'b0;
      id_shift <= '0;
    end else if (tck_enable) begin
      if (dec.capture_dr) begin
        bypass   <= 1'b0;
        id_shift <= IDCODE_VAL;
      end
      if (dec.shift_dr) begin
        bypass   <= tdi;
        id_shift <= {tdi, id_shift[31:1]};
      end
    end
  end

  // DR selection from the active instruction; unknown opcodes fall to bypass
  always_comb begin
    dr_sel = DR_BYPASS;
    if (ir_active == IR_EXTEST || ir_active == IR_SAMPLE) dr_sel = DR_BSR;
    else if (ir_active == IR_IDCODE)                      dr_sel = DR_IDCODE;
  end

  // TDO mux and boundary-scan control decode
  always_comb begin
    tdo = 1'b0;
    if (dec.shift_ir) begin
      tdo = ir_shift[0];
    end else if (dec.shift_dr) begin
      unique case (dr_sel)
        DR_BSR:    tdo = bsr_scan_out;
        DR_IDCODE: tdo = id_shift[0];
        default:   tdo = bypass;
      endcase
    end
    tdo_oe               = dec.shift_dr | dec.shift_ir;
    bsr_tck_enable       = tck_enable;
    bsr_test_logic_reset = dec.tlr;
    bsr_capture          = dec.capture_dr & (dr_sel == DR_BSR);
    bsr_shift_data       = dec.shift_dr   & (dr_sel == DR_BSR);
    bsr_update           = dec.update_dr  & (dr_sel == DR_BSR);
    bsr_mode             = (ir_active == IR_EXTEST);
    bsr_scan_in          = tdi;
  end

endmodule
`default_nettype wire

// File: tb/tb_jtag_tap_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jtag_tap_controller
//  Description : Directed self-checking bench for jtag_tap_controller with a
//                4-cell boundary-scan chain model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jtag_tap_controller;

  localparam logic [31:0] C_IDCODE = 32'h1BA5_E0F3;
  localparam logic [3:0]  C_PINS   = 4'b1010;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tck_enable = 1'b0;
  logic tms = 1'b1;
  logic tdi = 1'b0;
  logic tdo, tdo_oe, bsr_tck_enable, bsr_test_logic_reset;
  logic bsr_capture, bsr_shift_data, bsr_update, bsr_mode, bsr_scan_in, bsr_scan_out;

  int n_cmp = 0;
  int n_err = 0;
  int gap_max = 0;
  int cnt_cap, cnt_shift, cnt_upd;
  logic [3:0] chain = '0;
  logic [3:0] upd_reg = '0;

  jtag_tap_controller #(.IR_WIDTH(4), .IDCODE_VAL(C_IDCODE)) dut (
    .internal_clk         (clk),
    .tap_reset_n          (rst_n),
    .tck_enable           (tck_enable),
    .tms                  (tms),
    .tdi                  (tdi),
    .tdo                  (tdo),
    .tdo_oe               (tdo_oe),
    .bsr_tck_enable       (bsr_tck_enable),
    .bsr_test_logic_reset (bsr_test_logic_reset),
    .bsr_capture          (bsr_capture),
    .bsr_shift_data       (bsr_shift_data),
    .bsr_update           (bsr_update),
    .bsr_mode             (bsr_mode),
    .bsr_scan_in          (bsr_scan_in),
    .bsr_scan_out         (bsr_scan_out)
  );

  always #5 clk = ~clk;

  // 4-cell boundary-scan chain model with constant pin values
  assign bsr_scan_out = chain[0];
  always @(posedge clk) begin
    if (bsr_tck_enable) begin
      if (bsr_capture)         chain <= C_PINS;
      else if (bsr_shift_data) chain <= {bsr_scan_in, chain[3:1]};
      if (bsr_update)          upd_reg <= chain;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One TCK strobe, preceded by a random idle gap; outputs sampled mid-strobe
  task automatic step(input logic m, input logic d, output logic o);
    int g;
    g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
    repeat (g) @(negedge clk);
    @(negedge clk);
    tms = m; tdi = d; tck_enable = 1'b1;
    #1;
    o = tdo;
    if (bsr_capture)    cnt_cap++;
    if (bsr_shift_data) cnt_shift++;
    if (bsr_update)     cnt_upd++;
    @(posedge clk);
    #1;
    tck_enable = 1'b0;
  endtask

  task automatic scan_ir(input logic [3:0] op, output logic [3:0] cap);
    logic o;
    step(1, 0, o); step(1, 0, o); step(0, 0, o); step(0, 0, o);
    for (int i = 0; i < 4; i++) begin
      step(i == 3, op[i], o);
      cap[i] = o;
    end
    step(1, 0, o); step(0, 0, o);
  endtask

  task automatic scan_dr(input logic [31:0] din, input int n, output logic [31:0] dout);
    logic o;
    cnt_cap = 0; cnt_shift = 0; cnt_upd = 0;
    dout = '0;
    step(1, 0, o); step(0, 0, o); step(0, 0, o);
    for (int i = 0; i < n; i++) begin
      step(i == n - 1, din[i], o);
      dout[i] = o;
    end
    step(1, 0, o); step(0, 0, o);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  cap;
    logic [31:0] dout;
    logic        o;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tlr",  {31'd0, bsr_test_logic_reset}, 32'd1);
    check("rst_oe",   {31'd0, tdo_oe}, 32'd0);
    check("rst_tdo",  {31'd0, tdo}, 32'd0);
    check("rst_ctl",  {28'd0, bsr_capture, bsr_shift_data, bsr_update, bsr_mode}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_tlr", {31'd0, bsr_test_logic_reset}, 32'd1);

    // IDCODE read straight after reset
    step(0, 0, o);
    scan_dr(32'd0, 32, dout);
    check("idcode_first2", {30'd0, dout[1:0]}, 32'd3);
    check("idcode_read", dout, C_IDCODE);
    check("idcode_no_bsr", cnt_cap + cnt_shift + cnt_upd, 32'd0);

    // EXTEST: IR capture pattern, mode and BSR control pulses
    scan_ir(4'b0000, cap);
    check("ir_capture", {28'd0, cap}, 32'd1);
    check("extest_mode", {31'd0, bsr_mode}, 32'd1);
    scan_dr(32'h6, 4, dout);
    check("extest_tdo", dout, {28'd0, C_PINS});
    check("extest_cap", cnt_cap, 32'd1);
    check("extest_shift", cnt_shift, 32'd4);
    check("extest_upd", cnt_upd, 32'd1);
    check("extest_updreg", {28'd0, upd_reg}, 32'h6);

    // BYPASS: one-bit delay with leading capture zero
    scan_ir(4'b1111, cap);
    check("byp_ir_capture", {28'd0, cap}, 32'd1);
    check("byp_mode", {31'd0, bsr_mode}, 32'd0);
    scan_dr(32'hD, 4, dout);
    check("byp_tdo", dout, 32'hA);
    check("byp_no_shift", cnt_shift, 32'd0);

    // SAMPLE_PRELOAD selects BSR without EXTEST mode
    scan_ir(4'b0010, cap);
    check("smp_mode", {31'd0, bsr_mode}, 32'd0);
    scan_dr(32'h9, 4, dout);
    check("smp_tdo", dout, {28'd0, C_PINS});
    check("smp_shift", cnt_shift, 32'd4);

    // Random idle gaps between strobes
    gap_max = 3;
    scan_ir(4'b0001, cap);
    check("gap_ir_capture", {28'd0, cap}, 32'd1);
    scan_dr(32'hFFFF_0000, 32, dout);
    check("gap_idcode", dout, C_IDCODE);
    scan_ir(4'b0101, cap);
    scan_dr(32'hD, 4, dout);
    check("gap_unused_byp", dout, 32'hA);
    check("gap_unused_mode", {31'd0, bsr_mode}, 32'd0);
    check("gap_unused_shift", cnt_shift, 32'd0);
    gap_max = 0;

    // Reset asserted in SHIFT_DR under EXTEST
    scan_ir(4'b0000, cap);
    step(1, 0, o); step(0, 0, o); step(0, 0, o); step(0, 1, o);
    check("pre_rst_oe", {31'd0, tdo_oe}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tlr", {31'd0, bsr_test_logic_reset}, 32'd1);
    check("mid_rst_oe", {31'd0, tdo_oe}, 32'd0);
    check("mid_rst_iract", {28'd0, dut.ir_active}, 32'd1);
    check("mid_rst_mode", {31'd0, bsr_mode}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Five tms=1 strobes from PAUSE_IR reach TEST_LOGIC_RESET
    step(0, 0, o); step(1, 0, o); step(1, 0, o); step(0, 0, o);
    step(0, 0, o); step(1, 0, o); step(0, 0, o);
    for (int i = 0; i < 4; i++) step(1, 0, o);
    check("tms4_not_tlr", {31'd0, bsr_test_logic_reset}, 32'd0);
    check("tms4_extest", {31'd0, bsr_mode}, 32'd1);
    step(1, 0, o);
    check("tms5_tlr", {31'd0, bsr_test_logic_reset}, 32'd1);
    step(1, 0, o);
    check("tlr_mode", {31'd0, bsr_mode}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/jtag_tap_controller.md
# jtag_tap_controller

IEEE 1149.1-style TAP controller for the FPGA JTAG chain. It decodes TMS/TDI samples from the JTAG front end into the 16-state TAP state machine. It owns the instruction, bypass and IDCODE registers, and drives the capture, shift, update, mode and test-logic-reset controls of the boundary scan register (BSR), a chain of boundary scan cells. Everything runs on the system clock `internal_clk`, qualified by a one-cycle TCK-edge strobe, matching the clocking of the boundary scan cells.

## Interface
Parameters:
- IR_WIDTH, 4, instruction register width (≥2)
- IDCODE_VAL, 32'h1BA5_E0F3, device identification value (bit 0 must be 1)

Ports:
- internal_clk  in  1  system clock
- tap_reset_n  in  1  asynchronous active-low reset
- tck_enable  in  1  one-cycle strobe per TCK rising edge; tms/tdi valid in that cycle
- tms  in  1  test mode select
- tdi  in  1  test data in
- tdo  out  1  test data out (combinational mux, see Operation)
- tdo_oe  out  1  1 in SHIFT_DR or SHIFT_IR
- bsr_tck_enable  out  1  tck_enable passed through to all cells
- bsr_test_logic_reset  out  1  1 while in TEST_LOGIC_RESET
- bsr_capture  out  1  1 in CAPTURE_DR when BSR selected
- bsr_shift_data  out  1  1 in SHIFT_DR when BSR selected
- bsr_update  out  1  1 in UPDATE_DR when BSR selected
- bsr_mode  out  1  1 while active instruction is EXTEST
- bsr_scan_in  out  1  tdi passed through to the first cell
- bsr_scan_out  in  1  scan output of the last cell

## Operation
- TAP state advances only in cycles with tck_enable=1. The next state follows the standard 1149.1 TMS transition graph: TEST_LOGIC_RESET, RUN_TEST_IDLE, SELECT/CAPTURE/SHIFT/EXIT1/PAUSE/EXIT2/UPDATE for both DR and IR.
- Opcodes: EXTEST = all-0, SAMPLE_PRELOAD = 'b0010, IDCODE = 'b0001, BYPASS = all-1. Every other opcode behaves as BYPASS.
- BSR is the selected DR for EXTEST and SAMPLE_PRELOAD. IDCODE selects the 32-bit ID register. All other opcodes select the 1-bit bypass register.
- Register updates in a tck_enable cycle depend on the current state:
  - CAPTURE_IR: ir_shift ← {0…0,01}.
  - SHIFT_IR: ir_shift ← {tdi, ir_shift[IR_WIDTH-1:1]}.
  - UPDATE_IR: ir_active ← ir_shift.
  - CAPTURE_DR: bypass ← 0; id_shift ← IDCODE_VAL.
  - SHIFT_DR: bypass ← tdi; id_shift ← {tdi, id_shift[31:1]}.
- All registers shift LSB first.
- tdo = ir_shift[0] in SHIFT_IR. In SHIFT_DR it is bsr_scan_out, id_shift[0] or bypass, according to the selected DR. Otherwise tdo = 0.
- In TEST_LOGIC_RESET, ir_active ← IDCODE on every tck_enable cycle, so bsr_mode = 0.
- BSR control outputs are pure decodes of the current state and ir_active, so cells act in the same tck_enable cycle as the controller.

## Timing
- Reset values:
  - Registers: state = TEST_LOGIC_RESET, ir_active = IDCODE, ir_shift = 0, bypass = 0, id_shift = 0.
  - Outputs: tdo = 0, tdo_oe = 0, bsr_test_logic_reset = 1, bsr_capture/bsr_shift_data/bsr_update/bsr_mode = 0.
- Reset assertion mid-scan aborts immediately; partial ir_shift contents are discarded.
- With tck_enable=0 nothing changes, including the TAP state.
- Five consecutive tck_enable cycles with tms=1 reach TEST_LOGIC_RESET from any state.
- tdo bit n reflects the register before the n-th shifting edge. The first bit is valid in the cycle the state enters SHIFT_xR.
- The last shift happens on the edge that leaves SHIFT_xR for EXIT1 with tms=1; that edge still shifts.
- ir_active changes in the cycle after the UPDATE_IR tck_enable cycle. bsr_mode follows in the same cycle.

## Structure
- Shared package `jtag_pkg`:
  - `tap_state_e`, a 4-bit enum of the 16 states
  - opcode localparams
  - the `dr_sel_e` enum: BSR, IDCODE, BYPASS
- Sub-module `jtag_tap_fsm`:
  - contains the state register and next-state logic
  - outputs the one-hot state decodes
- The top level holds the IR, DR registers, tdo mux and BSR control decode.

## Test plan
- Reset: pulse tap_reset_n low mid-SHIFT_DR → bsr_test_logic_reset=1, tdo_oe=0, ir_active=IDCODE. Then five tms=1 strobes from PAUSE_IR → TEST_LOGIC_RESET.
- IDCODE read: tms 0,1,0,0 then 32 shifts with tdi=0 → tdo stream is IDCODE_VAL LSB first (1,1,0,0,1,1,1,1,…).
- IR scan:
  - shift opcode 0000 → first two tdo bits are 1,0 (captured 0001).
  - After UPDATE_IR: bsr_mode=1 and bsr_update pulses exactly once on the next UPDATE_DR.
- BYPASS: IR=1111, shift tdi pattern 1,0,1,1 → tdo is 0,1,0,1 (one-bit delay, leading 0 from capture).
- EXTEST DR scan with bsr_scan_out tied to a 4-bit model chain:
  - bsr_capture is high only in the CAPTURE_DR strobe cycle.
  - bsr_shift_data is high for exactly 4 strobes.
  - bsr_update is high for 1 strobe.
- Gaps: insert tck_enable=0 cycles of random length between strobes → identical tdo sequence. Unused opcode 0101 → behaves as BYPASS.
